// File: rtl/zcted_pkg.sv
// zcted_pkg: shared constants and helpers for the zero-crossing TED timing loop.
//   PKG_*        default configuration of the loop
//   calc_w_nom   nominal NCO control word, 2^(NCO_W-SPS_LOG2)
//   W_NOM        nominal control word for the default configuration
//   calc_cnt_w   width of a lock counter that must hold 0..lock_cnt
//   LOCK_CNT_W   lock-counter width for the default configuration
//   sat_acc      clamps a wide signed value to the signed range of a w-bit accumulator
package zcted_pkg;

  localparam int PKG_ACC_W    = 32;
  localparam int PKG_NCO_W    = 16;
  localparam int PKG_SPS_LOG2 = 2;
  localparam int PKG_LOCK_CNT = 16;

  function automatic int calc_w_nom(input int nco_w, input int sps_log2);
    return 1 << (nco_w - sps_log2);
  endfunction

  localparam int W_NOM = calc_w_nom(PKG_NCO_W, PKG_SPS_LOG2);

  function automatic int calc_cnt_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

  localparam int LOCK_CNT_W = calc_cnt_w(PKG_LOCK_CNT);

  // Callers pass their ACC_W+1 wide sum sign-extended to 64 bits and keep the
  // low w bits of the result.
  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] x,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/zcted_pi_filter.sv
// zcted_pi_filter: proportional-integral loop filter for the timing loop.
//   clk, rst    clock, synchronous active-low reset
//   ted_valid   e_k is valid; integrator and v_k update the following cycle
//   e_k         signed TED error
//   v_k         saturated filter output, held between valid samples
module zcted_pi_filter
  import zcted_pkg::*;
#(
  parameter int ERR_W    = 16,
  parameter int ACC_W    = PKG_ACC_W,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ted_valid,
  input  logic signed [ERR_W-1:0] e_k,
  output logic signed [ACC_W-1:0] v_k
);

  logic signed [ACC_W-1:0] integ;
  logic signed [ACC_W:0]   e_ext;
  logic signed [ACC_W:0]   p_term;
  logic signed [ACC_W:0]   i_term;
  logic signed [ACC_W:0]   i_sum;
  logic signed [ACC_W:0]   v_sum;
  logic signed [ACC_W-1:0] i_new;
  logic signed [ACC_W-1:0] v_new;

  assign e_ext  = (ACC_W+1)'(e_k);
  assign p_term = e_ext >>> KP_SHIFT;
  assign i_term = e_ext >>> KI_SHIFT;

  // The proportional path uses the freshly saturated integrator value.
  assign i_sum = (ACC_W+1)'(integ) + i_term;
  assign i_new = ACC_W'(sat_acc(64'(i_sum), ACC_W));
  assign v_sum = p_term + (ACC_W+1)'(i_new);
  assign v_new = ACC_W'(sat_acc(64'(v_sum), ACC_W));

  always_ff @(posedge clk) begin
    if (!rst) begin
      integ <= '0;
      v_k   <= '0;
    end else if (ted_valid) begin
      integ <= i_new;
      v_k   <= v_new;
    end
  end

endmodule

// File: rtl/zcted_timing_loop.sv
// zcted_timing_loop: symbol timing recovery loop between the zero-crossing TED
// and the cubic interpolator. PI loop filter, modulo-1 decrementing NCO that
// yields the symbol strobe and fractional interval mu, and a hysteretic lock
// detector.
//   clk, rst    clock, synchronous active-low reset
//   in_valid    one input sample this cycle; the NCO steps only on these cycles
//   ted_valid   e_k valid this cycle
//   freeze      (only with ZCTED_LOOP_FREEZE_EN) holds filter and lock counter
//   e_k         signed TED error
//   strobe      one-cycle symbol strobe
//   mu          fractional interval (MU_FRAC fraction bits), valid with strobe
//   v_k         loop filter output
//   lock        timing lock flag
// Build option: define ZCTED_LOOP_FREEZE_EN to add the freeze input.
module zcted_timing_loop
  import zcted_pkg::*;
#(
  parameter int ERR_W    = 16,
  parameter int ACC_W    = PKG_ACC_W,
  parameter int NCO_W    = PKG_NCO_W,
  parameter int SPS_LOG2 = PKG_SPS_LOG2,
  parameter int MU_WIDTH = 10,
  parameter int MU_FRAC  = 9,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 8,
  parameter int VK_SHIFT = 0,
  parameter int LOCK_THR = 256,
  parameter int LOCK_CNT = PKG_LOCK_CNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    ted_valid,
`ifdef ZCTED_LOOP_FREEZE_EN
  input  logic                    freeze,
`endif
  input  logic signed [ERR_W-1:0] e_k,
  output logic                    strobe,
  output logic [MU_WIDTH-1:0]     mu,
  output logic signed [ACC_W-1:0] v_k,
  output logic                    lock
);

  localparam int W_NOM_CFG = calc_w_nom(NCO_W, SPS_LOG2);
  localparam int CNT_W     = calc_cnt_w(LOCK_CNT);
  localparam logic signed [ACC_W:0] W_LO = (ACC_W+1)'(W_NOM_CFG / 2);
  localparam logic signed [ACC_W:0] W_HI = (ACC_W+1)'(3 * W_NOM_CFG / 2);

  logic loop_en;
`ifdef ZCTED_LOOP_FREEZE_EN
  assign loop_en = ted_valid & ~freeze;
`else
  assign loop_en = ted_valid;
`endif

  zcted_pi_filter #(
    .ERR_W   (ERR_W),
    .ACC_W   (ACC_W),
    .KP_SHIFT(KP_SHIFT),
    .KI_SHIFT(KI_SHIFT)
  ) u_pi (
    .clk      (clk),
    .rst      (rst),
    .ted_valid(loop_en),
    .e_k      (e_k),
    .v_k      (v_k)
  );

  // NCO control word: nominal step plus scaled v_k, clamped to +/-50 %.
  logic signed [ACC_W-1:0] v_scaled;
  logic signed [ACC_W:0]   w_raw;
  logic [NCO_W-1:0]        w_ctl;

  assign v_scaled = v_k >>> VK_SHIFT;
  assign w_raw    = (ACC_W+1)'(v_scaled) + (ACC_W+1)'(W_NOM_CFG);

  always_comb begin
    w_ctl = w_raw[NCO_W-1:0];
    if (w_raw < W_LO)      w_ctl = NCO_W'(W_NOM_CFG / 2);
    else if (w_raw > W_HI) w_ctl = NCO_W'(3 * W_NOM_CFG / 2);
  end

  logic [NCO_W-1:0]        eta;
  logic signed [NCO_W+1:0] diff;
  logic                    underflow;
  logic [MU_FRAC-1:0]      mu_bits;

  assign diff      = $signed({2'b00, eta}) - $signed({2'b00, w_ctl});
  assign underflow = diff < (NCO_W+2)'(0);
  // Top MU_FRAC bits of (eta << SPS_LOG2) taken modulo 2^NCO_W.
  assign mu_bits   = eta[NCO_W-1-SPS_LOG2 -: MU_FRAC];

  // On underflow the wrapped value diff + 2^NCO_W has the same low NCO_W bits
  // as diff, so both branches load the same slice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      eta    <= '1;
      strobe <= 1'b0;
      mu     <= '0;
    end else begin
      strobe <= 1'b0;
      if (in_valid) begin
        eta <= diff[NCO_W-1:0];
        if (underflow) begin
          strobe <= 1'b1;
          mu     <= MU_WIDTH'(mu_bits);
        end
      end
    end
  end

  // Lock detector. |e_k| needs one extra bit for the most-negative input.
  logic signed [ERR_W:0] e_ext;
  logic [ERR_W:0]        e_abs;
  logic                  in_range;
  logic [CNT_W-1:0]      lock_cnt;
  logic [CNT_W-1:0]      cnt_next;

  assign e_ext    = {e_k[ERR_W-1], e_k};
  assign e_abs    = e_ext[ERR_W] ? (ERR_W+1)'(-e_ext) : e_ext;
  assign in_range = e_abs < (ERR_W+1)'(LOCK_THR);

  always_comb begin
    cnt_next = lock_cnt;
    if (in_range) begin
      if (lock_cnt != CNT_W'(LOCK_CNT)) cnt_next = lock_cnt + CNT_W'(1);
    end else if (lock_cnt != '0) begin
      cnt_next = lock_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (loop_en) begin
      lock_cnt <= cnt_next;
      if (cnt_next == CNT_W'(LOCK_CNT)) lock <= 1'b1;
      else if (cnt_next == '0)          lock <= 1'b0;
    end
  end

endmodule

// File: doc/zcted_timing_loop.md
Name: zcted_timing_loop

Overview:
Parametrised timing-recovery control loop for the QPSK symbol timing synchroniser. It sits between the zero-crossing TED and the cubic interpolator.
- A PI loop filter turns TED error samples into a control value v_k.
- A modulo-1 decrementing NCO produces the symbol strobe and the fractional interval mu.
- A hysteretic lock detector drives a lock flag.
- It is generalised in samples-per-symbol, NCO resolution and loop gains, and adds a sample-valid handshake and lock indication.

Parameters:
ERR_W, 16, TED error width (signed)
ACC_W, 32, integrator and v_k width (signed)
NCO_W, 16, NCO register width (unsigned, modulo 2^NCO_W)
SPS_LOG2, 2, log2 of samples per symbol (SPS = 4)
MU_WIDTH, 10, mu output width (unsigned)
MU_FRAC, 9, mu fractional bits
KP_SHIFT, 4, proportional gain = 2^-KP_SHIFT
KI_SHIFT, 8, integral gain = 2^-KI_SHIFT
VK_SHIFT, 0, arithmetic right shift applied to v_k before the NCO
LOCK_THR, 256, |e_k| threshold for the lock detector
LOCK_CNT, 16, lock counter ceiling

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  one input sample per asserted cycle; the NCO advances only on these cycles
ted_valid  in  1  e_k is valid this cycle
e_k  in  ERR_W  signed TED error
strobe  out  1  symbol strobe, one-cycle pulse
mu  out  MU_WIDTH  fractional interval, unsigned, MU_FRAC fraction bits; valid while strobe=1
v_k  out  ACC_W  loop-filter output, signed
lock  out  1  timing lock indication

Behaviour:
- Reset (rst=0 at a clk edge):
  - strobe=0, mu=0, v_k=0, lock=0.
  - Integrator=0, lock counter=0, eta=all ones.
  - Reset applies mid-operation with no residue; the first strobe after release follows the free-run sequence.
- Loop filter (updates only when ted_valid=1):
  - p = e_k>>>KP_SHIFT; i_new = sat(integ + (e_k>>>KI_SHIFT)); v_k <= sat(p + i_new).
  - All arithmetic is sign-extended to ACC_W+1 and saturated to the ACC_W signed range.
  - v_k updates the cycle after ted_valid.
  - When ted_valid=0, integ and v_k hold.
- NCO control word:
  - W_NOM = 2^(NCO_W-SPS_LOG2).
  - W = W_NOM + (v_k>>>VK_SHIFT), clamped to [W_NOM/2, 3*W_NOM/2].
  - Positive v_k gives more frequent strobes.
- NCO step (when in_valid=1):
  - diff = eta - W, computed at NCO_W+2 signed width.
  - If diff<0: eta <= diff + 2^NCO_W; strobe <= 1; mu <= top MU_FRAC bits of (eta << SPS_LOG2), using eta before the update, zero-extended to MU_WIDTH.
  - Else: eta <= diff; strobe <= 0.
- When in_valid=0: eta holds, strobe <= 0, mu holds.
- Latency: strobe and mu are registered one cycle after the in_valid that underflows.
- Simultaneous ted_valid and in_valid: the NCO uses the pre-update v_k; the new v_k takes effect on the next in_valid.
- Lock detector (updates on ted_valid):
  - |e_k| < LOCK_THR: counter +1, saturating at LOCK_CNT.
  - Otherwise: counter -1, saturating at 0.
  - lock <= 1 when counter reaches LOCK_CNT; lock <= 0 when counter reaches 0; otherwise lock holds (hysteresis).
  - |e_k| uses ERR_W+1 bits so that the most-negative value is handled correctly.

Optional Feature:
ZCTED_LOOP_FREEZE_EN
- Defined: adds input port freeze (1 bit). While freeze=1, the integrator, v_k and the lock counter hold regardless of ted_valid. The NCO keeps running using the held v_k.
- Undefined: no freeze port; behaviour is as above.

Decomposition:
- Package zcted_pkg holds:
  - function sat_acc (ACC_W+1 to ACC_W saturation);
  - localparam W_NOM derivation;
  - the lock-counter width constant $clog2(LOCK_CNT+1).
- One sub-module, zcted_pi_filter: loop filter plus saturation, with ports clk, rst, ted_valid, e_k, v_k.
- The NCO and lock detector live in the top.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with in_valid=1 -> strobe=0, mu=0, v_k=0, lock=0; release -> first strobe on the 4th in_valid with mu=511 (eta 0x3FFF << 2 -> 0x1FF).
2. Free-run with defaults, v_k=0, in_valid=1 continuous -> strobe every 4 cycles, mu=511 each time, no drift over 4096 cycles.
3. in_valid toggling 1,0,1,0 -> strobe every 8 cycles; eta and mu unchanged on in_valid=0 cycles.
4. ted_valid once with e_k=+1024 -> next cycle integ=4, v_k=68; W=0x4044, so strobe spacing shortens and mu decreases by 0x44<<2 per symbol; e_k=-32768 repeated -> integ saturates at -2^31 with no wrap.
5. Lock: 16 consecutive e_k=100 -> lock rises after the 16th; then e_k=1000 x15 -> lock stays 1; 16th -> lock=0.
6. Reset asserted mid-stream while lock=1 and v_k≠0 -> all outputs 0 the next cycle; post-release strobe timing is identical to test 1.
